sys_ctrl_regfile: RTL

- Command front-end that sits directly upstream of the 8x16 register file.
- Parses byte frames from the UART receiver into single-cycle register-file write and read strobes.
- Forwards read-back data to the UART transmitter, respecting the transmitter's busy handshake.
- Supported frames: write = 0xAA, ADDR, DATA; read = 0xBB, ADDR.

---
 rtl/sys_ctrl_regfile.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sys_ctrl_regfile.sv
// Command front-end: turns UART byte frames (0xAA,ADDR,DATA / 0xBB,ADDR) into register-file
// strobes and returns read data to the UART transmitter. Optional inter-byte timeout: CMD_TIMEOUT_EN.
module sys_ctrl_regfile #(
   parameter int WIDTH          = 8,
   parameter int ADDRESS_WIDTH  = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [WIDTH-1:0]         RX_P_Data,
   input  logic                     RX_D_VLD,
   input  logic [WIDTH-1:0]         RdData,
   input  logic                     RdData_Valid,
   input  logic                     TX_Busy,
   output logic [ADDRESS_WIDTH-1:0] Address,
   output logic [WIDTH-1:0]         WrData,
   output logic                     WrEn,
   output logic                     RdEn,
   output logic [WIDTH-1:0]         TX_P_Data,
   output logic                     TX_D_VLD,
   output logic                     Frame_Err
);

   localparam logic [WIDTH-1:0] CMD_WR = WIDTH'(8'hAA);
   localparam logic [WIDTH-1:0] CMD_RD = WIDTH'(8'hBB);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      WR_EXEC = 3'd3,
      RD_ADDR = 3'd4,
      RD_EXEC = 3'd5,
      RD_WAIT = 3'd6,
      TX_SEND = 3'd7
   } state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [ADDRESS_WIDTH-1:0] adr_out_q, adr_out_d;
   logic [WIDTH-1:0]         data_q, data_d;
   logic [WIDTH-1:0]         wrdata_q, wrdata_d;
   logic [WIDTH-1:0]         txdata_q, txdata_d;
   logic                     wren_q, wren_d;
   logic                     rden_q, rden_d;
   logic                     txvld_q, txvld_d;
   logic                     ferr_q, ferr_d;
   logic                     tmo_hit_s;

`ifdef CMD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_q;
   logic             tmo_run_s;

   assign tmo_run_s = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR);
   assign tmo_hit_s = tmo_run_s && !RX_D_VLD && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   // Inter-byte counter: counts idle cycles mid-frame, cleared by any byte or outside a frame.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tmo_q <= {TMO_W{1'b0}};
      end else if (tmo_run_s && !RX_D_VLD && !tmo_hit_s) begin
         tmo_q <= tmo_q + TMO_W'(1);
      end else begin
         tmo_q <= {TMO_W{1'b0}};
      end
   end
`else
   assign tmo_hit_s = 1'b0;
   // Without the timeout a stalled frame simply waits; TIMEOUT_CYCLES has no effect here.
   if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
   end
`endif

   // Frame parser: next state, address/data latches and next values of the registered outputs.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      adr_out_d = adr_out_q;
      wrdata_d  = wrdata_q;
      txdata_d  = txdata_q;
      wren_d    = 1'b0;
      rden_d    = 1'b0;
      txvld_d   = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_Data == CMD_WR) begin
                  state_d = WR_ADDR;
               end else if (RX_P_Data == CMD_RD) begin
                  state_d = RD_ADDR;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WR_ADDR, RD_ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_Data[ADDRESS_WIDTH-1:0];
               state_d = (state_q == WR_ADDR) ? WR_DATA : RD_EXEC;
            end else if (tmo_hit_s) begin
               state_d = IDLE;
               ferr_d  = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               data_d  = RX_P_Data;
               state_d = WR_EXEC;
            end else if (tmo_hit_s) begin
               state_d = IDLE;
               ferr_d  = 1'b1;
            end else begin
               state_d = WR_DATA;
            end
         end
         WR_EXEC: begin
            adr_out_d = addr_q;
            wrdata_d  = data_q;
            wren_d    = 1'b1;
            state_d   = IDLE;
         end
         RD_EXEC: begin
            adr_out_d = addr_q;
            rden_d    = 1'b1;
            state_d   = RD_WAIT;
         end
         RD_WAIT: begin
            if (RdData_Valid) begin
               data_d  = RdData;
               state_d = TX_SEND;
            end else begin
               state_d = RD_WAIT;
            end
         end
         TX_SEND: begin
            if (!TX_Busy) begin
               txdata_d = data_q;
               txvld_d  = 1'b1;
               state_d  = IDLE;
            end else begin
               state_d = TX_SEND;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, latches and output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         addr_q    <= {ADDRESS_WIDTH{1'b0}};
         data_q    <= {WIDTH{1'b0}};
         adr_out_q <= {ADDRESS_WIDTH{1'b0}};
         wrdata_q  <= {WIDTH{1'b0}};
         txdata_q  <= {WIDTH{1'b0}};
         wren_q    <= 1'b0;
         rden_q    <= 1'b0;
         txvld_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         adr_out_q <= adr_out_d;
         wrdata_q  <= wrdata_d;
         txdata_q  <= txdata_d;
         wren_q    <= wren_d;
         rden_q    <= rden_d;
         txvld_q   <= txvld_d;
         ferr_q    <= ferr_d;
      end
   end

   assign Address   = adr_out_q;
   assign WrData    = wrdata_q;
   assign WrEn      = wren_q;
   assign RdEn      = rden_q;
   assign TX_P_Data = txdata_q;
   assign TX_D_VLD  = txvld_q;
   assign Frame_Err = ferr_q;

endmodule
